pipeline_control_unit: RTL and testbench

//  Central stall/flush sequencer for the RV32I 5-stage pipeline (IF/ID/EX/MEM/WB). Combines hazard

---
 rtl/pipe_ctrl_pkg.sv | 61 ++++++
 rtl/pipe_perf_counter.sv | 32 +++
 rtl/pipeline_control_unit.sv | 145 ++++++++++++++
 tb/tb_pipeline_control_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared types and control-bundle layout for the pipeline control unit.
// Revision: 1.0
// ============================================================================
package pipe_ctrl_pkg;

  localparam int c_STATE_W = 2;

  typedef enum logic [c_STATE_W-1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HAZ  = 2'd2,
    ST_MEMW = 2'd3
  } state_t;

  // Bit positions of the enable/flush outputs inside the control bundle
  localparam int c_CTL_W        = 9;
  localparam int c_PC_EN        = 8;
  localparam int c_IF_ID_EN     = 7;
  localparam int c_IF_ID_FLUSH  = 6;
  localparam int c_ID_EX_EN     = 5;
  localparam int c_ID_EX_FLUSH  = 4;
  localparam int c_EX_MEM_EN    = 3;
  localparam int c_EX_MEM_FLUSH = 2;
  localparam int c_MEM_WB_EN    = 1;
  localparam int c_MEM_WB_FLUSH = 0;

  typedef logic [c_CTL_W-1:0] ctl_t;

  function automatic ctl_t make_ctl(
    input logic pc_en,
    input logic if_id_en,  input logic if_id_flush,
    input logic id_ex_en,  input logic id_ex_flush,
    input logic ex_mem_en, input logic ex_mem_flush,
    input logic mem_wb_en, input logic mem_wb_flush
  );
    ctl_t v;
    v                 = '0;
    v[c_PC_EN]        = pc_en;
    v[c_IF_ID_EN]     = if_id_en;
    v[c_IF_ID_FLUSH]  = if_id_flush;
    v[c_ID_EX_EN]     = id_ex_en;
    v[c_ID_EX_FLUSH]  = id_ex_flush;
    v[c_EX_MEM_EN]    = ex_mem_en;
    v[c_EX_MEM_FLUSH] = ex_mem_flush;
    v[c_MEM_WB_EN]    = mem_wb_en;
    v[c_MEM_WB_FLUSH] = mem_wb_flush;
    return v;
  endfunction

  localparam ctl_t c_CTL_INIT   = make_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
  localparam ctl_t c_CTL_RUN    = make_ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  localparam ctl_t c_CTL_FREEZE = make_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam ctl_t c_CTL_BRANCH = make_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
  localparam ctl_t c_CTL_HAZ    = make_ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
  localparam ctl_t c_CTL_IMEM   = make_ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

endpackage
`default_nettype wire

// File: rtl/pipe_perf_counter.sv
`default_nettype none
// ============================================================================
// Module  : pipe_perf_counter
// Brief   : Free-running wrapping event counter with enable and synchronous clear.
// Revision: 1.0
// ============================================================================
module pipe_perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_control_unit
// Brief   : Stall/flush sequencer driving PC and all RV32I pipeline registers.
//           Define PIPE_PERF_CNT_EN to add stall/flush performance counters.
// Revision: 1.0
// ============================================================================
module pipeline_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES    = 2,
  parameter int HAZ_MAX_CYCLES = 8,
  parameter int CNT_W          = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        ex_mem_flush,
  output logic        mem_wb_en,
  output logic        mem_wb_flush,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        stall_timeout
);

  localparam logic [CNT_W-1:0] c_INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_HAZ_MAX   = CNT_W'(HAZ_MAX_CYCLES);
  localparam logic [CNT_W-1:0] c_HAZ_LAST  = CNT_W'(HAZ_MAX_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_init_cnt;
  logic [CNT_W-1:0] w_init_cnt_nxt;
  logic [CNT_W-1:0] r_haz_cnt;
  logic [CNT_W-1:0] w_haz_cnt_nxt;
  logic             r_stall_timeout;
  logic             w_stall_timeout_nxt;
  ctl_t             w_ctl;
  logic             w_branch_honoured;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_INIT;
      r_init_cnt      <= '0;
      r_haz_cnt       <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_init_cnt      <= w_init_cnt_nxt;
      r_haz_cnt       <= w_haz_cnt_nxt;
      r_stall_timeout <= w_stall_timeout_nxt;
    end
  end

  // RUN, HAZ and MEMW share one priority decode; the state only records history
  always_comb begin
    w_state_nxt         = r_state;
    w_init_cnt_nxt      = r_init_cnt;
    w_haz_cnt_nxt       = r_haz_cnt;
    w_stall_timeout_nxt = r_stall_timeout;
    w_ctl               = c_CTL_INIT;
    w_branch_honoured   = 1'b0;

    if (r_state == ST_INIT) begin
      w_init_cnt_nxt = r_init_cnt + 1'b1;
      if (r_init_cnt == c_INIT_LAST) begin
        w_state_nxt    = ST_RUN;
        w_init_cnt_nxt = '0;
      end
    end else if (dmem_busy) begin
      w_ctl       = c_CTL_FREEZE;
      w_state_nxt = ST_MEMW;
    end else if (branch_taken) begin
      w_ctl             = c_CTL_BRANCH;
      w_state_nxt       = ST_RUN;
      w_haz_cnt_nxt     = '0;
      w_branch_honoured = 1'b1;
    end else if (hazard_stall) begin
      w_ctl       = c_CTL_HAZ;
      w_state_nxt = ST_HAZ;
      if (r_haz_cnt < c_HAZ_MAX) begin
        w_haz_cnt_nxt = r_haz_cnt + 1'b1;
      end
      if (r_haz_cnt == c_HAZ_LAST) begin
        w_stall_timeout_nxt = 1'b1;
      end
    end else if (imem_busy) begin
      w_ctl         = c_CTL_IMEM;
      w_state_nxt   = ST_RUN;
      w_haz_cnt_nxt = '0;
    end else begin
      w_ctl         = c_CTL_RUN;
      w_state_nxt   = ST_RUN;
      w_haz_cnt_nxt = '0;
    end
  end

  assign pc_en         = w_ctl[c_PC_EN];
  assign if_id_en      = w_ctl[c_IF_ID_EN];
  assign if_id_flush   = w_ctl[c_IF_ID_FLUSH];
  assign id_ex_en      = w_ctl[c_ID_EX_EN];
  assign id_ex_flush   = w_ctl[c_ID_EX_FLUSH];
  assign ex_mem_en     = w_ctl[c_EX_MEM_EN];
  assign ex_mem_flush  = w_ctl[c_EX_MEM_FLUSH];
  assign mem_wb_en     = w_ctl[c_MEM_WB_EN];
  assign mem_wb_flush  = w_ctl[c_MEM_WB_FLUSH];
  assign stall_timeout = r_stall_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic w_in_init;
  assign w_in_init = (r_state == ST_INIT);

  pipe_perf_counter #(.WIDTH(32)) u_perf_stall (
    .clk     (clk),
    .rst     (reset),
    .i_en    (!w_in_init && !w_ctl[c_PC_EN]),
    .i_clr   (w_in_init),
    .o_count (perf_stall_cnt)
  );

  pipe_perf_counter #(.WIDTH(32)) u_perf_flush (
    .clk     (clk),
    .rst     (reset),
    .i_en    (w_branch_honoured),
    .i_clr   (w_in_init),
    .o_count (perf_flush_cnt)
  );
`else
  logic w_unused_ok;
  assign w_unused_ok = w_branch_honoured;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_control_unit
// Brief   : Self-checking bench for pipeline_control_unit with a rule-level model.
// Revision: 1.0
// ============================================================================
module tb_pipeline_control_unit;

  localparam int INIT_CYCLES    = 2;
  localparam int HAZ_MAX_CYCLES = 8;

  logic clk = 1'b0;
  logic reset, hazard_stall, branch_taken, imem_busy, dmem_busy;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, stall_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipeline_control_unit #(
    .INIT_CYCLES(INIT_CYCLES), .HAZ_MAX_CYCLES(HAZ_MAX_CYCLES), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .hazard_stall(hazard_stall), .branch_taken(branch_taken),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
    .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
`ifdef PIPE_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  // Order: pc, if_id en/flush, id_ex en/flush, ex_mem en/flush, mem_wb en/flush
  logic [8:0] obs_ctl;
  assign obs_ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                    ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush};

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_init_left;
  int          m_haz;
  bit          m_to;
  logic [31:0] m_perf_stall;
  logic [31:0] m_perf_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_ctl(input logic h, input logic b, input logic i, input logic d);
    logic pc, ie, ifl, xe, xfl, me, mfl, we, wfl;
    if (m_init_left > 0) begin
      // flushing every register, nothing loads
      pc = 0; ie = 0; ifl = 1; xe = 0; xfl = 1; me = 0; mfl = 1; we = 0; wfl = 1;
    end else begin
      pc = 1; ie = 1; ifl = 0; xe = 1; xfl = 0; me = 1; mfl = 0; we = 1; wfl = 0;
      if (d) begin
        pc = 0; ie = 0; xe = 0; me = 0; we = 0;
      end else if (b) begin
        ifl = 1; xfl = 1;
      end else if (h) begin
        pc = 0; ie = 0; xfl = 1;
      end else if (i) begin
        pc = 0; ifl = 1;
      end
    end
    return {pc, ie, ifl, xe, xfl, me, mfl, we, wfl};
  endfunction

  task automatic model_reset();
    m_init_left  = INIT_CYCLES;
    m_haz        = 0;
    m_to         = 0;
    m_perf_stall = '0;
    m_perf_flush = '0;
  endtask

  task automatic model_clock(input logic h, input logic b, input logic i, input logic d);
    logic [8:0] e;
    e = exp_ctl(h, b, i, d);
    if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      if (!e[8]) m_perf_stall++;
      if (d) begin
        // counter frozen along with the pipeline
      end else if (b) begin
        m_haz = 0;
        m_perf_flush++;
      end else if (h) begin
        if (m_haz == HAZ_MAX_CYCLES - 1) m_to = 1;
        if (m_haz < HAZ_MAX_CYCLES) m_haz++;
      end else begin
        m_haz = 0;
      end
    end
  endtask

  task automatic step(input logic h, input logic b, input logic i, input logic d, input string tag);
    hazard_stall = h; branch_taken = b; imem_busy = i; dmem_busy = d;
    @(negedge clk);
    chk({tag, "_ctl"}, 32'(obs_ctl), 32'(exp_ctl(h, b, i, d)));
    chk({tag, "_timeout"}, 32'(stall_timeout), 32'(m_to));
`ifdef PIPE_PERF_CNT_EN
    chk({tag, "_perf_stall"}, perf_stall_cnt, m_perf_stall);
    chk({tag, "_perf_flush"}, perf_flush_cnt, m_perf_flush);
`endif
    @(posedge clk);
    model_clock(h, b, i, d);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    hazard_stall = 1; branch_taken = 1; imem_busy = 1; dmem_busy = 0;
    model_reset();
    #2;
    chk("reset_ctl", 32'(obs_ctl), 32'(9'b001010101));
    chk("reset_timeout", 32'(stall_timeout), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    hazard_stall = 0; branch_taken = 0; imem_busy = 0; dmem_busy = 0;
    model_reset();
    @(posedge clk);
    apply_reset();

    // Init sequence ignores inputs, then full run outputs
    step(1, 1, 1, 1, "init0");
    step(1, 0, 1, 1, "init1");
    step(0, 0, 0, 0, "run_first");
    chk("run_first_exact", 32'(obs_ctl), 32'(9'b110101010));

    // Two-cycle hazard then release
    step(1, 0, 0, 0, "haz1");
    step(1, 0, 0, 0, "haz2");
    step(0, 0, 0, 0, "haz_release");

    // Branch beats hazard and clears the stall count
    step(1, 0, 0, 0, "pre_br_haz");
    step(1, 1, 0, 0, "br_haz");
    chk("br_haz_cnt", 32'(dut.r_haz_cnt), 32'(m_haz));

    // Full freeze dominates everything
    step(1, 1, 1, 1, "freeze");
    chk("freeze_state", 32'(dut.r_state), 32'd3);
    step(0, 0, 1, 0, "imem");
    step(0, 0, 0, 0, "idle");

    // Hazard across a memory wait keeps its count
    step(1, 0, 0, 0, "hm1");
    step(1, 0, 0, 1, "hm_wait");
    step(1, 0, 0, 0, "hm2");
    chk("hm_cnt", 32'(dut.r_haz_cnt), 32'(m_haz));
    step(0, 0, 0, 0, "hm_release");

    // Watchdog: 8 consecutive stall cycles
    for (int k = 0; k < HAZ_MAX_CYCLES; k++) step(1, 0, 0, 0, $sformatf("wd%0d", k));
    chk("wd_timeout_set", 32'(stall_timeout), 32'd1);
    step(0, 0, 0, 0, "wd_after1");
    step(1, 1, 0, 0, "wd_after2");
    chk("wd_timeout_sticky", 32'(stall_timeout), 32'd1);

    // Randomised traffic against the model
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 3) == 0, ($urandom % 7) == 0, ($urandom % 4) == 0,
           ($urandom % 8) == 0, $sformatf("rnd%0d", k));
    end
    // Long stall burst inside random traffic to exercise saturation
    for (int k = 0; k < 12; k++) step(1, 0, $urandom % 2, ($urandom % 5) == 0, $sformatf("sat%0d", k));

    // Async reset in the middle of a hazard stall
    apply_reset();
    step(0, 0, 0, 0, "r_init0");
    step(0, 0, 0, 0, "r_init1");
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, $sformatf("mid%0d", k));
    chk("mid_cnt5", 32'(dut.r_haz_cnt), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid_reset_ctl", 32'(obs_ctl), 32'(9'b001010101));
    chk("mid_reset_timeout", 32'(stall_timeout), 32'd0);
    chk("mid_reset_cnt", 32'(dut.r_haz_cnt), 32'd0);
    chk("mid_reset_state", 32'(dut.r_state), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1, 0, 0, 0, "post_init0");
    step(1, 0, 0, 0, "post_init1");
    step(1, 0, 0, 0, "post_haz");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
